// File: rtl/pipe_sym_pkg.sv
// Shared PIPE TX symbol codes, K-flag encodings and framer state encoding.
// The framer and the SKP scheduler both import this package.
package pipe_sym_pkg;

    localparam logic [7:0] K_STP    = 8'hFB;
    localparam logic [7:0] K_END    = 8'hFD;
    localparam logic [7:0] K_EDB    = 8'hFE;
    localparam logic [7:0] K_COM    = 8'hBC;
    localparam logic [7:0] K_SKP    = 8'h1C;
    localparam logic [7:0] IDLE_SYM = 8'h00;

    // One K-flag per byte lane; bit0 covers the earlier symbol in [7:0].
    localparam logic [1:0] CTL_NONE = 2'b00;
    localparam logic [1:0] CTL_LO   = 2'b01;
    localparam logic [1:0] CTL_HI   = 2'b10;
    localparam logic [1:0] CTL_BOTH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_END   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SKP0  = 3'd4,
        ST_SKP1  = 3'd5
    } tx_state_e;

endpackage

// File: rtl/pipe_skp_sched.sv
// Free-running SKP interval timer; raises skp_pending on expiry and holds
// it until the framer takes the ordered set. At most one SKP is ever owed.
module pipe_skp_sched #(
    parameter int SKP_INTERVAL = 590
) (
    input  logic clk,
    input  logic rst,
    input  logic skp_taken,
    output logic skp_pending
);

    localparam int CW = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 2;
    localparam logic [CW-1:0] RELOAD = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pend_q;
    logic          pend_d;
    logic          expire;

    assign expire = (cnt_q == '0);

    // An expiry coinciding with a take re-arms the request for the next slot.
    always_comb begin
        cnt_d  = expire ? RELOAD : (cnt_q - 1'b1);
        pend_d = expire | (pend_q & ~skp_taken);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= RELOAD;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign skp_pending = pend_q;

endmodule

// File: rtl/pipe_tx_framer.sv
// PIPE TX framer: wraps 16-bit link-layer beats in STP/END, nullifies with EDB
// on source underrun, and slots SKP ordered sets in between packets.
module pipe_tx_framer
    import pipe_sym_pkg::*;
#(
    parameter int SKP_INTERVAL = 590
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tx_en_in,
    input  logic        s_valid_in,
    output logic        s_ready_out,
    input  logic [15:0] s_data_in,
    input  logic        s_first_in,
    input  logic        s_last_in,
    output logic [15:0] tx_data_out,
    output logic [1:0]  tx_ctl_out,
    output logic        err_underrun_out,
    output logic        err_framing_out
);

    tx_state_e   state_q;
    tx_state_e   state_d;
    tx_state_e   state_eff;
    logic [7:0]  hold_q;
    logic [7:0]  hold_d;
    logic [15:0] data_q;
    logic [15:0] data_d;
    logic [1:0]  ctl_q;
    logic [1:0]  ctl_d;
    logic        unf_q;
    logic        unf_d;
    logic        frm_q;
    logic        frm_d;
    logic        s_ready;
    logic        skp_taken;
    logic        skp_pending;

    pipe_skp_sched #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_sched (
        .clk        (clk_in),
        .rst        (rst_in),
        .skp_taken  (skp_taken),
        .skp_pending(skp_pending)
    );

    always_comb begin
        // A pending SKP pre-empts IDLE in the same cycle, so the ordered set
        // follows END with no idle gap and a competing packet stalls 2 cycles.
        state_eff = state_q;
        if ((state_q == ST_IDLE) && skp_pending) begin
            state_eff = ST_SKP0;
        end

        state_d   = state_q;
        hold_d    = hold_q;
        data_d    = {IDLE_SYM, IDLE_SYM};
        ctl_d     = CTL_NONE;
        unf_d     = 1'b0;
        frm_d     = 1'b0;
        s_ready   = 1'b0;
        skp_taken = 1'b0;

        case (state_eff)
            ST_IDLE: begin
                s_ready = tx_en_in | ~s_first_in;
                if (s_valid_in && s_ready) begin
                    if (s_first_in) begin
                        data_d  = {s_data_in[7:0], K_STP};
                        ctl_d   = CTL_LO;
                        hold_d  = s_data_in[15:8];
                        state_d = s_last_in ? ST_END : ST_DATA;
                    end else begin
                        frm_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                s_ready = 1'b1;
                if (s_valid_in) begin
                    data_d = {s_data_in[7:0], hold_q};
                    hold_d = s_data_in[15:8];
                    if (s_last_in) begin
                        state_d = ST_END;
                    end
                end else begin
                    data_d  = {K_EDB, hold_q};
                    ctl_d   = CTL_HI;
                    unf_d   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_END: begin
                data_d  = {K_END, hold_q};
                ctl_d   = CTL_HI;
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                s_ready = 1'b1;
                if (s_valid_in && s_last_in) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SKP0: begin
                data_d    = {K_SKP, K_COM};
                ctl_d     = CTL_BOTH;
                skp_taken = 1'b1;
                state_d   = ST_SKP1;
            end
            ST_SKP1: begin
                data_d  = {K_SKP, K_SKP};
                ctl_d   = CTL_BOTH;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            hold_q  <= 8'h00;
            data_q  <= 16'h0000;
            ctl_q   <= CTL_NONE;
            unf_q   <= 1'b0;
            frm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            ctl_q   <= ctl_d;
            unf_q   <= unf_d;
            frm_q   <= frm_d;
        end
    end

    assign s_ready_out      = s_ready;
    assign tx_data_out      = data_q;
    assign tx_ctl_out       = ctl_q;
    assign err_underrun_out = unf_q;
    assign err_framing_out  = frm_q;

endmodule

// File: tb/tb_pipe_tx_framer.sv
// Randomized scoreboard bench for pipe_tx_framer: a symbol-stream reference
// model predicts each registered output cycle; a monitor pops and compares.
module tb_pipe_tx_framer;

    localparam int SKP_I = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        tx_en_in = 1'b0;
    logic        s_valid_in = 1'b0;
    logic        s_ready_out;
    logic [15:0] s_data_in = 16'h0000;
    logic        s_first_in = 1'b0;
    logic        s_last_in = 1'b0;
    logic [15:0] tx_data_out;
    logic [1:0]  tx_ctl_out;
    logic        err_underrun_out;
    logic        err_framing_out;

    always #5 clk_in = ~clk_in;

    pipe_tx_framer #(
        .SKP_INTERVAL(SKP_I)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tx_en_in        (tx_en_in),
        .s_valid_in      (s_valid_in),
        .s_ready_out     (s_ready_out),
        .s_data_in       (s_data_in),
        .s_first_in      (s_first_in),
        .s_last_in       (s_last_in),
        .tx_data_out     (tx_data_out),
        .tx_ctl_out      (tx_ctl_out),
        .err_underrun_out(err_underrun_out),
        .err_framing_out (err_framing_out)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  ctl;
        logic        unf;
        logic        frm;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: symbols waiting to go out, as {K, byte}, oldest first.
    logic [8:0] sym_q[$];
    bit m_pkt, m_close, m_drain, m_owed, m_skp2;
    int m_k;

    function automatic bit model_ready(input bit f, input bit en);
        if (m_skp2 || m_close) return 1'b0;
        if (m_pkt || m_drain)  return 1'b1;
        if (m_owed)            return 1'b0;
        return en | ~f;
    endfunction

    function automatic void pop2(output logic [15:0] dd, output logic [1:0] cc);
        logic [8:0] s0;
        logic [8:0] s1;
        s0 = sym_q.pop_front();
        s1 = sym_q.pop_front();
        dd = {s1[7:0], s0[7:0]};
        cc = {s1[8], s0[8]};
    endfunction

    task automatic model_step(input bit rst, input bit v, input bit f, input bit l,
                              input logic [15:0] d, input bit rdy, output bit acc);
        exp_t e;
        e   = '0;
        acc = 1'b0;
        if (rst) begin
            sym_q.delete();
            m_pkt = 0; m_close = 0; m_drain = 0; m_owed = 0; m_skp2 = 0;
            m_k = 0;
            sb_q.push_back(e);
            return;
        end
        acc = v & rdy;
        if (m_skp2) begin
            e.data = 16'h1C1C; e.ctl = 2'b11; m_skp2 = 0;
        end else if (m_close) begin
            sym_q.push_back({1'b1, 8'hFD});
            pop2(e.data, e.ctl);
            m_close = 0;
        end else if (m_pkt) begin
            if (v) begin
                sym_q.push_back({1'b0, d[7:0]});
                sym_q.push_back({1'b0, d[15:8]});
                pop2(e.data, e.ctl);
                if (l) begin m_pkt = 0; m_close = 1; end
            end else begin
                sym_q.push_back({1'b1, 8'hFE});
                pop2(e.data, e.ctl);
                e.unf = 1'b1;
                m_pkt = 0; m_drain = 1;
            end
        end else if (m_drain) begin
            if (v && l) m_drain = 0;
        end else if (m_owed) begin
            e.data = 16'h1CBC; e.ctl = 2'b11; m_owed = 0; m_skp2 = 1;
        end else if (acc) begin
            if (f) begin
                sym_q.push_back({1'b1, 8'hFB});
                sym_q.push_back({1'b0, d[7:0]});
                sym_q.push_back({1'b0, d[15:8]});
                pop2(e.data, e.ctl);
                if (l) m_close = 1; else m_pkt = 1;
            end else begin
                e.frm = 1'b1;
            end
        end
        // A SKP request is raised every SKP_I cycles counted from reset release.
        if ((m_k % SKP_I) == SKP_I - 1) m_owed = 1;
        m_k++;
        sb_q.push_back(e);
    endtask

    task automatic cycle(input bit rst, input bit v, input bit f, input bit l,
                         input bit en, input logic [15:0] d, output bit acc);
        bit rdy;
        @(negedge clk_in);
        rst_in = rst; s_valid_in = v; s_first_in = f; s_last_in = l;
        tx_en_in = en; s_data_in = d;
        #1;
        rdy = model_ready(f, en);
        if (!rst) begin
            n_tests++;
            if (s_ready_out !== rdy) begin
                n_fail++;
                $display("FAIL s_ready: got %b expected %b at t=%0t", s_ready_out, rdy, $time);
            end
        end
        model_step(rst, v, f, l, d, rdy, acc);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if ({tx_data_out, tx_ctl_out, err_underrun_out, err_framing_out} !== e) begin
                    n_fail++;
                    $display("FAIL tx_out: got data=%h ctl=%b unf=%b frm=%b expected data=%h ctl=%b unf=%b frm=%b at t=%0t",
                             tx_data_out, tx_ctl_out, err_underrun_out, err_framing_out,
                             e.data, e.ctl, e.unf, e.frm, $time);
                end else if (e.ctl == 2'b10) begin
                    $display("[TB] t=%0t packet closed: data=%h ctl=%b unf=%b",
                             $time, tx_data_out, tx_ctl_out, err_underrun_out);
                end
            end
        end
    end

    initial begin
        bit          a;
        bit          rst, v, f, l, en, stray;
        int          rem;
        int          plen;
        logic [15:0] d;

        repeat (3) cycle(1, 0, 0, 0, 1, 16'h0000, a);
        // 4-beat packet 01..08
        cycle(0, 1, 1, 0, 1, 16'h0201, a);
        cycle(0, 1, 0, 0, 1, 16'h0403, a);
        cycle(0, 1, 0, 0, 1, 16'h0605, a);
        cycle(0, 1, 0, 1, 1, 16'h0807, a);
        repeat (12) cycle(0, 0, 0, 0, 1, 16'h0000, a);
        // Underrun after the second beat, then the rest is drained.
        cycle(0, 1, 1, 0, 1, 16'h0201, a);
        cycle(0, 1, 0, 0, 1, 16'h0403, a);
        cycle(0, 0, 0, 0, 1, 16'h0000, a);
        cycle(0, 1, 0, 0, 1, 16'h0605, a);
        cycle(0, 1, 0, 1, 1, 16'h0807, a);
        repeat (2) cycle(0, 0, 0, 0, 1, 16'h0000, a);
        // Stray non-first beat in IDLE.
        cycle(0, 1, 0, 0, 1, 16'hAA55, a);
        repeat (2) cycle(0, 0, 0, 0, 1, 16'h0000, a);
        // Reset while mid-packet.
        cycle(0, 1, 1, 0, 1, 16'h1211, a);
        cycle(0, 1, 0, 0, 1, 16'h1413, a);
        cycle(1, 1, 0, 0, 1, 16'h1615, a);
        repeat (20) cycle(0, 0, 0, 0, 1, 16'h0000, a);

        rem = 0;
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            en    = ($urandom_range(0, 9) != 0);
            v     = ($urandom_range(0, 7) != 0);
            stray = (rem == 0) && ($urandom_range(0, 19) == 0);
            plen  = $urandom_range(1, 6);
            d     = 16'($urandom);
            if (rem == 0) begin
                f = !stray;
                l = stray ? 1'($urandom_range(0, 1)) : (plen == 1);
            end else begin
                f = 1'b0;
                l = (rem == 1);
            end
            cycle(rst, v, f, l, en, d, a);
            if (a) begin
                if (f) rem = plen - 1;
                else if (rem > 0) rem--;
            end
        end

        @(posedge clk_in);
        #2;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_tx_framer.md
# pipe_tx_framer

Transmit-side counterpart of the PIPE RX tap path: accepts packet bytes from the link layer on a 16-bit valid/ready stream and drives 2-symbol-per-clock PIPE TX data/control toward the PHY. It frames each packet with STP/END K-symbols, emits logical idle between packets, and inserts SKP ordered sets on a fixed interval. It nullifies a packet with EDB on source underrun.

## Interface
- SKP_INTERVAL, default 590: clock cycles between SKP ordered-set requests; 590 cycles is 1180 symbol times. Legal range ≥ 4.
- clk_in  in  1  symbol clock, 2 symbols/cycle.
- rst_in  in  1  reset, synchronous, active-high.
- tx_en_in  in  1  permit packet starts; sampled only in IDLE.
- s_valid_in  in  1  source beat valid.
- s_ready_out  out  1  beat accepted when s_valid_in & s_ready_out.
- s_data_in  in  16  two bytes; [7:0] is earlier in time.
- s_first_in  in  1  first beat of packet.
- s_last_in  in  1  last beat of packet. Packets are whole beats (even byte count).
- tx_data_out  out  16  PIPE TX symbols; [7:0] is lane-0/earlier symbol.
- tx_ctl_out  out  2  K-flag per byte; bit0 covers [7:0].
- err_underrun_out  out  1  1-cycle pulse: packet nullified.
- err_framing_out  out  1  1-cycle pulse: beat without s_first_in consumed in IDLE.

## Operation
- Symbols: STP=FB, END=FD, EDB=FE, COM=BC, SKP=1C, all K. Idle = 00 data.
- States: IDLE, DATA, DRAIN, SKP0, SKP1. A one-byte hold register carries the odd byte across beats.
- IDLE has three cases, in priority order:
  - skp_pending set: go to SKP0.
  - tx_en_in & s_valid_in & s_first_in: accept the beat and emit {s_data[7:0], STP} with ctl 01. Hold s_data[15:8]. Go to DATA, or to END if s_last_in.
  - Otherwise emit 0000, ctl 00.
- IDLE with s_valid_in & !s_first_in: consume the beat, discard it, pulse err_framing_out, emit idle.
- DATA with s_valid_in: accept the beat and emit {s_data[7:0], hold} with ctl 00. Update hold. If s_last_in, go to END.
- DATA with !s_valid_in (underrun): emit {EDB, hold} with ctl 10 and pulse err_underrun_out.
  - Go to DRAIN.
- END is a one-cycle substate of DATA. It emits {END, hold} with ctl 10, then goes to IDLE with s_ready_out low that cycle.
- DRAIN: s_ready_out=1 and emit idle. Discard beats until an accepted beat with s_last_in, then go to IDLE. No further error pulses.
- SKP0 emits {SKP, COM}, ctl 11. SKP1 emits {SKP, SKP}, ctl 11, then goes to IDLE. skp_pending clears on entering SKP0.
- SKP scheduler:
  - Down-counter loads SKP_INTERVAL-1 and is free-running.
  - At zero it sets skp_pending and reloads.
  - Expiry while pending already set is absorbed: one SKP is owed at most.
  - SKP is never inserted mid-packet; it waits for IDLE.
- s_ready_out is combinational from state/regs and tx_en_in:
  - IDLE: 1 if !skp_pending & (tx_en_in | !s_first_in).
  - DATA (not END) and DRAIN: 1.
  - Otherwise 0.

## Timing
- tx_data_out, tx_ctl_out and the error pulses are registered. An accepted beat appears on tx outputs the next cycle.
- Packet of N beats occupies N+1 output cycles (STP cycle + N-1 data + END), plus zero gap before the next STP.
- Back-to-back packets: the next STP can follow END directly. IDLE after END accepts first_in in the same cycle, giving 0 idle cycles.
- Reset values:
  - tx_data_out=0000, tx_ctl_out=00, both error outputs 0.
  - State IDLE, hold=00, skp_pending=0, counter=SKP_INTERVAL-1.
- Reset mid-packet: outputs are idle the next cycle. No END/EDB is emitted and the partial packet is abandoned.
- Simultaneous SKP expiry and packet start in IDLE: SKP wins and the packet is stalled 2 cycles.

## Structure
- Package pipe_sym_pkg holds the K-code constants (STP, END, EDB, COM, SKP), the state enum, and the ctl encodings.
- Sub-module pipe_skp_sched holds the down-counter and skp_pending set/clear. Its inputs are clk, rst and skp_taken; its output is skp_pending.
- The top holds the FSM, the hold byte and the output registers.

## Test plan
- Packet of 4 beats, bytes 01..08: tx sequence {01,FB}/01, {03,02}/00, {05,04}/00, {07,06}/00, {FD,08}/10, then 0000/00.
- SKP_INTERVAL=8 with no traffic: the pattern 1CBC/11, 1C1C/11 repeats every 8 cycles. Idle 0000/00 fills the gaps.
- SKP_INTERVAL=8, 6-beat packet spanning expiry: no SKP symbols inside the packet; SKP0/SKP1 appear immediately after END.
- Underrun after 2nd beat of 01..08: {FE,04}/10 and an err_underrun pulse. Beats 05..08 are consumed with no output; idle follows.
- Beat with first=0 in IDLE: it is consumed, err_framing pulses, and tx stays 0000/00.
- rst_in asserted during DATA: the next cycle shows 0000/00 with state IDLE. The first SKP arrives SKP_INTERVAL cycles after reset release.
